seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 Parameter BLANK_CYC, default 64, dark cycles at the start of each slot to suppress ghosting (legal 0..SCAN_DIV-1).
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = segment and anode outputs active-low, 0 = active-high.
REQ-005 clock  input  1  single system clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
REQ-008 load  input  1  when high, value is captured into the shadow register at the clock edge.
REQ-009 blank_mask  input  DIGITS  bit i high forces digit i dark.
REQ-010 anode  output  DIGITS  one-hot digit enable, registered.
REQ-011 segments  output  7  registered segment pattern, bit order g,f,e,d,c,b,a (bit 6 = g).
REQ-012 frame  output  1  registered one-cycle pulse marking start of a new scan frame.

Function
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index idx SHALL advance by 1 when cnt wraps, with idx wrapping DIGITS-1 -> 0.
REQ-014 Outputs SHALL be registered from the current cnt/idx/shadow state, giving a fixed one-cycle latency.
REQ-015 Digit idx SHALL be lit only when cnt >= BLANK_CYC, blank_mask[idx] = 0 and the digit is not suppressed (REQ-024); otherwise anode all inactive and segments all off.
REQ-016 Active-low codes for nibbles 0..F SHALL be 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); with ACTIVE_LOW=0 the bitwise inverse applies, as does the anode polarity.
REQ-017 frame SHALL pulse for one cycle in the cycle after cnt wraps with idx = DIGITS-1 (i.e. aligned with the first cycle of digit 0's slot at the outputs).
REQ-018 load SHALL update the shadow register at that edge, with the new nibbles visible on segments one cycle later regardless of slot position; load on every cycle is legal.
REQ-019 With load and a prescaler wrap in the same cycle, both SHALL take effect; the new slot displays the new value.
REQ-020 blank_mask SHALL be sampled live (unregistered into shadow) and affects output one cycle later.
REQ-021 With DIGITS=1, idx SHALL remain 0 and frame SHALL pulse on every prescaler wrap.

Reset
REQ-022 While reset is high at an edge: cnt=0, idx=0, shadow=0, anode all inactive, segments all off (7F active-low), frame=0.
REQ-023 Reset asserted mid-slot or mid-frame SHALL abort scanning immediately; the first lit output after release is digit 0 after BLANK_CYC+1 cycles.

Configuration
REQ-024 Macro SEVEN_SEG_LZB_EN: when defined, digit i (i > 0) SHALL be suppressed if nibble i and all higher nibbles of the shadow register are zero; digit 0 is never suppressed, so value 0 shows a single "0". When undefined, no suppression and all digits display their nibble.

Verification
REQ-025 DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, ACTIVE_LOW=1; load value=0x1234 -> digit 0 slot: anode=1110, segments=19 for 3 cycles after 1 dark cycle; digits 1,2,3 show 30,24,79 in order; frame pulses every 16 cycles.
REQ-026 Same config, value=0x00A0 with SEVEN_SEG_LZB_EN -> digits 3,2 dark (anode 1111), digit 1 = 08, digit 0 = 40; without the macro digits 3,2 show 40.
REQ-027 blank_mask=0010 with value=0xFFFF -> digit 1 slot fully dark; other digits show 0E.
REQ-028 Load 0x5555 in the wrap cycle from digit 1 to digit 2 -> first lit cycle of digit 2 shows 12; no stale nibble visible.
REQ-029 Assert reset for 1 cycle during digit 2 slot -> next cycle anode=1111, segments=7F, frame=0; scan restarts at digit 0, first frame pulse 16 cycles later.
REQ-030 ACTIVE_LOW=0, value=0x8 -> digit 0 anode=0001, segments=7F.

Source files
------------

// File: rtl/seven_seg_scanner.sv
//============================================================================
// Module   : seven_seg_scanner
// Brief    : Time-multiplexed hex driver for a multi-digit seven-segment
//            display. A prescaler sweeps the digit index, a shadow register
//            holds the nibbles, and every output is registered, so outputs
//            lag the scan state by one cycle. Each slot opens with a short
//            dark window that suppresses ghosting between digits.
//            Optional leading-zero blanking is enabled by defining the
//            SEVEN_SEG_LZB_EN macro.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module seven_seg_scanner #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            segments,
    output logic                  frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow;
    logic                frame_pend;

    logic                wrap;
    logic                in_window;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   supp_vec;
    logic [3:0]          cur_nib;
    logic                cur_mask;
    logic                cur_supp;
    logic                lit;
    logic [DIGITS-1:0]   anode_hi;
    logic [6:0]          seg_hi;

    // Active-low segment code (bit 6 = g ... bit 0 = a) for one hex nibble.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    assign wrap = (cnt == CNT_LAST);

    // The first BLANK_CYC cycles of every slot are kept dark.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_window = 1'b1;
        end else begin : g_blank
            assign in_window = (cnt >= CNT_W'(BLANK_CYC));
        end
    endgenerate

`ifdef SEVEN_SEG_LZB_EN
    // zero_from[i] is high when nibble i and every nibble above it are zero.
    // Digit 0 is never suppressed so an all-zero value still shows "0".
    logic [DIGITS:0] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_lzb
            assign zero_from[g] = (shadow[4*g +: 4] == 4'h0) && zero_from[g+1];
            if (g == 0) begin : g_digit0
                assign supp_vec[g] = 1'b0;
            end else begin : g_upper
                assign supp_vec[g] = zero_from[g];
            end
        end
    endgenerate
`else
    assign supp_vec = '0;
`endif

    // Select the nibble, mask bit and suppression flag of the current digit.
    always_comb begin
        cur_nib  = 4'h0;
        cur_mask = 1'b0;
        cur_supp = 1'b0;
        onehot   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow[4*i +: 4];
                cur_mask  = blank_mask[i];
                cur_supp  = supp_vec[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Next output values in active-high sense; polarity applied at the register.
    always_comb begin
        lit      = in_window && !cur_mask && !cur_supp;
        anode_hi = lit ? onehot : '0;
        seg_hi   = lit ? ~seg_code(cur_nib) : 7'h00;
    end

    // Prescaler and digit index; idx steps only when the prescaler wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Shadow register captures the display value whenever load is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    // Frame marker is delayed one extra cycle so it lines up with digit 0 at the outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_pend <= 1'b0;
            frame      <= 1'b0;
        end else begin
            frame_pend <= wrap && (idx == IDX_LAST);
            frame      <= frame_pend;
        end
    end

    // Registered drive of anode and segment pins in the selected polarity.
    always_ff @(posedge clock) begin
        if (reset) begin
            anode    <= (ACTIVE_LOW != 0) ? '1 : '0;
            segments <= (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
        end else begin
            anode    <= (ACTIVE_LOW != 0) ? ~anode_hi : anode_hi;
            segments <= (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
//============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Directed bench for seven_seg_scanner. Main instance uses
//            DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low; a second
//            single-digit active-high instance covers the other polarity.
//            Expectations follow SEVEN_SEG_LZB_EN when it is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  mask;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        frame;

    logic        rst2;
    logic [3:0]  value2;
    logic        load2;
    logic [0:0]  mask2;
    logic [0:0]  anode2;
    logic [6:0]  segments2;
    logic        frame2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       frm;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];

    seven_seg_scanner #(
        .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1)
    ) dut (
        .clock(clk), .reset(rst), .value(value), .load(load),
        .blank_mask(mask), .anode(anode), .segments(segments), .frame(frame)
    );

    seven_seg_scanner #(
        .DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0)
    ) dut_hi (
        .clock(clk), .reset(rst2), .value(value2), .load(load2),
        .blank_mask(mask2), .anode(anode2), .segments(segments2), .frame(frame2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Push expected main-DUT outputs, clock once, then pop and compare.
    task automatic tick(input logic [3:0] an, input logic [6:0] seg, input logic frm, input string tag);
        exp_t e;
        exp_t g;
        e.an = an; e.seg = seg; e.frm = frm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({tag, ".anode"},    {4'h0, anode},    {4'h0, g.an});
        check({tag, ".segments"}, {1'b0, segments}, {1'b0, g.seg});
        check({tag, ".frame"},    {7'h0, frame},    {7'h0, g.frm});
    endtask

    // Position k (0..15) within a frame; codes holds one byte per digit, FF = dark.
    task automatic run_pos(input int k, input logic [31:0] codes, input bit first, input string tag);
        int d;
        int c;
        logic [7:0] cd;
        logic [3:0] an;
        d  = k / 4;
        c  = k % 4;
        cd = codes[d*8 +: 8];
        an = ~(4'b0001 << d);
        if (c == 0 || cd == 8'hFF)
            tick(4'hF, 7'h7F, first && (k == 0), tag);
        else
            tick(an, cd[6:0], 1'b0, tag);
    endtask

    task automatic run_frame(input logic [31:0] codes, input bit first, input string tag);
        for (int k = 0; k < 16; k++) run_pos(k, codes, first, tag);
    endtask

    initial begin
        exp_t e2;
        exp_t g2;
        logic [31:0] codes_a0;

        rst = 1'b1; load = 1'b0; value = 16'h0; mask = 4'h0;
        rst2 = 1'b1; load2 = 1'b0; value2 = 4'h0; mask2 = 1'b0;

        // Reset state
        tick(4'hF, 7'h7F, 1'b0, "reset0");
        tick(4'hF, 7'h7F, 1'b0, "reset1");

        // 0x1234: first frame after reset carries no frame pulse
        rst = 1'b0; load = 1'b1; value = 16'h1234;
        run_frame({8'h79, 8'h24, 8'h30, 8'h19}, 1'b0, "v1234_f0");
        run_frame({8'h79, 8'h24, 8'h30, 8'h19}, 1'b1, "v1234_f1");

        // 0x00A0: leading zeros blanked only when the feature is built in
        value = 16'h00A0;
`ifdef SEVEN_SEG_LZB_EN
        codes_a0 = {8'hFF, 8'hFF, 8'h08, 8'h40};
`else
        codes_a0 = {8'h40, 8'h40, 8'h08, 8'h40};
`endif
        run_frame(codes_a0, 1'b1, "v00A0");

        // 0xFFFF with digit 1 masked
        value = 16'hFFFF; mask = 4'b0010;
        run_frame({8'h0E, 8'h0E, 8'hFF, 8'h0E}, 1'b1, "mask1");

        // Load 0x5555 exactly on the digit 1 -> digit 2 wrap
        mask = 4'b0000; load = 1'b0; value = 16'h5555;
        for (int k = 0; k < 16; k++) begin
            load = (k == 7);
            run_pos(k, {8'h12, 8'h12, 8'h0E, 8'h0E}, 1'b1, "wrap_load");
        end
        load = 1'b0;

        // Reset in the middle of digit 2's slot
        for (int k = 0; k < 10; k++) run_pos(k, {4{8'h12}}, 1'b1, "pre_reset");
        rst = 1'b1;
        tick(4'hF, 7'h7F, 1'b0, "reset_mid");
        rst = 1'b0; load = 1'b1; value = 16'h5555;
        run_frame({4{8'h12}}, 1'b0, "post_reset_f0");
        run_frame({4{8'h12}}, 1'b1, "post_reset_f1");

        // Single-digit active-high instance; main instance parked in reset
        rst = 1'b1; load = 1'b0;
        e2.an = 4'h0; e2.seg = 7'h00; e2.frm = 1'b0;
        sb2.push_back(e2);
        tick(4'hF, 7'h7F, 1'b0, "park");
        g2 = sb2.pop_front();
        check("hi_reset.anode",    {7'h0, anode2},    {4'h0, g2.an});
        check("hi_reset.segments", {1'b0, segments2}, {1'b0, g2.seg});
        check("hi_reset.frame",    {7'h0, frame2},    {7'h0, g2.frm});

        rst2 = 1'b0; load2 = 1'b1; value2 = 4'h8;
        for (int k = 0; k < 9; k++) begin
            e2.an  = ((k % 4) != 0) ? 4'h1 : 4'h0;
            e2.seg = ((k % 4) != 0) ? 7'h7F : 7'h00;
            e2.frm = (k >= 4) && ((k % 4) == 0);
            sb2.push_back(e2);
            tick(4'hF, 7'h7F, 1'b0, "park");
            g2 = sb2.pop_front();
            check("hi_run.anode",    {7'h0, anode2},    {4'h0, g2.an});
            check("hi_run.segments", {1'b0, segments2}, {1'b0, g2.seg});
            check("hi_run.frame",    {7'h0, frame2},    {7'h0, g2.frm});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
